// File: rtl/ghost_catch_fsm_if.sv
// Game-side bundle for the ghost catch FSM: positions and tick in, catch/respawn status out.
// master drives the positions, tick and start; slave is the FSM.
interface ghost_catch_fsm_if;
    logic       tick;
    logic [9:0] ghost_x;
    logic [8:0] ghost_y;
    logic [9:0] pac_x;
    logic [8:0] pac_y;
    logic       start;
    logic       caught;
    logic       respawn;
    logic       freeze;
    logic [1:0] lives;
    logic       game_over;
    logic [1:0] state;
    logic       invuln;

    modport master (
        output tick, ghost_x, ghost_y, pac_x, pac_y, start,
        input  caught, respawn, freeze, lives, game_over, state, invuln
    );

    modport slave (
        input  tick, ghost_x, ghost_y, pac_x, pac_y, start,
        output caught, respawn, freeze, lives, game_over, state, invuln
    );
endinterface

// File: rtl/ghost_catch_fsm.sv
// Ghost/Pac-Man catch FSM: debounced collision, life accounting, freeze and respawn.
// Optional post-respawn invulnerability window is built when GHOST_CATCH_INVULN_EN is defined.
module ghost_catch_fsm #(
    parameter int HIT_RADIUS   = 8,
    parameter int LIVES        = 3,
    parameter int CONFIRM      = 2,
    parameter int FREEZE_TICKS = 60
) (
    input  logic               clkdiv,
    input  logic               rst,
    ghost_catch_fsm_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_CAUGHT = 2'd1,
        ST_OVER   = 2'd2,
        ST_BAD    = 2'd3
    } state_t;

    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [2:0]  CONFIRM_N  = 3'(CONFIRM);
    localparam logic [7:0]  FREEZE_N   = 8'(FREEZE_TICKS);
    localparam logic [10:0] RADIUS     = 11'(HIT_RADIUS);

    state_t      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [2:0]  confirm_q, confirm_d;
    logic [7:0]  freeze_cnt_q, freeze_cnt_d;
    logic        caught_q, caught_d;
    logic        respawn_q, respawn_d;
    logic [10:0] dx_s, dy_s;
    logic        overlap_s;
    logic        hit_s;
    logic        invuln_s;
    logic        freeze_s;
    logic        game_over_s;

    // Per-axis absolute distance, widened so the subtraction never wraps.
    always_comb begin
        if (bus.ghost_x >= bus.pac_x) begin
            dx_s = {1'b0, bus.ghost_x} - {1'b0, bus.pac_x};
        end else begin
            dx_s = {1'b0, bus.pac_x} - {1'b0, bus.ghost_x};
        end
        if (bus.ghost_y >= bus.pac_y) begin
            dy_s = {2'b00, bus.ghost_y} - {2'b00, bus.pac_y};
        end else begin
            dy_s = {2'b00, bus.pac_y} - {2'b00, bus.ghost_y};
        end
        overlap_s = (dx_s < RADIUS) && (dy_s < RADIUS);
    end

`ifdef GHOST_CATCH_INVULN_EN
    logic [4:0] inv_cnt_q, inv_cnt_d;

    assign invuln_s = (inv_cnt_q != 5'd0);

    // Invulnerability countdown, restarted by every respawn.
    always_comb begin
        if (respawn_d) begin
            inv_cnt_d = 5'd31;
        end else if (bus.tick && (inv_cnt_q != 5'd0)) begin
            inv_cnt_d = inv_cnt_q - 5'd1;
        end else begin
            inv_cnt_d = inv_cnt_q;
        end
    end

    // Invulnerability counter register.
    always_ff @(posedge clkdiv) begin
        if (!rst) begin
            inv_cnt_q <= 5'd0;
        end else begin
            inv_cnt_q <= inv_cnt_d;
        end
    end
`else
    assign invuln_s = 1'b0;
`endif

    assign hit_s = overlap_s & ~invuln_s;

    // State register plus counters and registered pulses.
    always_ff @(posedge clkdiv) begin
        if (!rst) begin
            state_q      <= ST_PLAY;
            lives_q      <= LIVES_INIT;
            confirm_q    <= 3'd0;
            freeze_cnt_q <= 8'd0;
            caught_q     <= 1'b0;
            respawn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            confirm_q    <= confirm_d;
            freeze_cnt_q <= freeze_cnt_d;
            caught_q     <= caught_d;
            respawn_q    <= respawn_d;
        end
    end

    // Next-state and counter update; only ticks advance the counters.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        confirm_d    = confirm_q;
        freeze_cnt_d = freeze_cnt_q;
        caught_d     = 1'b0;
        respawn_d    = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (bus.tick && hit_s) begin
                    if ((confirm_q + 3'd1) == CONFIRM_N) begin
                        caught_d  = 1'b1;
                        confirm_d = 3'd0;
                        if (lives_q != 2'd0) begin
                            lives_d = lives_q - 2'd1;
                        end else begin
                            lives_d = lives_q;
                        end
                        if (lives_q <= 2'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d      = ST_CAUGHT;
                            freeze_cnt_d = FREEZE_N;
                        end
                    end else begin
                        confirm_d = confirm_q + 3'd1;
                    end
                end else if (bus.tick) begin
                    confirm_d = 3'd0;
                end else begin
                    confirm_d = confirm_q;
                end
            end
            ST_CAUGHT: begin
                if (bus.tick && (freeze_cnt_q <= 8'd1)) begin
                    respawn_d    = 1'b1;
                    state_d      = ST_PLAY;
                    confirm_d    = 3'd0;
                    freeze_cnt_d = 8'd0;
                end else if (bus.tick) begin
                    freeze_cnt_d = freeze_cnt_q - 8'd1;
                end else begin
                    freeze_cnt_d = freeze_cnt_q;
                end
            end
            ST_OVER: begin
                if (bus.start) begin
                    lives_d   = LIVES_INIT;
                    respawn_d = 1'b1;
                    state_d   = ST_PLAY;
                    confirm_d = 3'd0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d   = ST_PLAY;
                confirm_d = 3'd0;
            end
        endcase
    end

    // Moore status outputs decoded from the state register.
    always_comb begin
        freeze_s    = 1'b0;
        game_over_s = 1'b0;
        case (state_q)
            ST_CAUGHT: begin
                freeze_s = 1'b1;
            end
            ST_OVER: begin
                freeze_s    = 1'b1;
                game_over_s = 1'b1;
            end
            default: begin
                freeze_s    = 1'b0;
                game_over_s = 1'b0;
            end
        endcase
    end

    assign bus.caught    = caught_q;
    assign bus.respawn   = respawn_q;
    assign bus.freeze    = freeze_s;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_s;
    assign bus.state     = state_q;
    assign bus.invuln    = invuln_s;

endmodule

// File: tb/tb_ghost_catch_fsm.sv
// Scoreboard bench for ghost_catch_fsm: a game-rule model queues expected outputs, a monitor compares.
// Honours GHOST_CATCH_INVULN_EN in the model when the macro is defined for the build.
module tb_ghost_catch_fsm;
    localparam int HIT_RADIUS   = 8;
    localparam int LIVES        = 3;
    localparam int CONFIRM      = 2;
    localparam int FREEZE_TICKS = 60;

    logic clkdiv = 1'b0;
    logic rst    = 1'b0;

    ghost_catch_fsm_if gif();

    ghost_catch_fsm #(
        .HIT_RADIUS  (HIT_RADIUS),
        .LIVES       (LIVES),
        .CONFIRM     (CONFIRM),
        .FREEZE_TICKS(FREEZE_TICKS)
    ) dut (
        .clkdiv(clkdiv),
        .rst   (rst),
        .bus   (gif.slave)
    );

    always #5 clkdiv = ~clkdiv;

    typedef struct packed {
        logic       caught;
        logic       respawn;
        logic [1:0] state;
        logic [1:0] lives;
        logic       freeze;
        logic       game_over;
        logic       invuln;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e, mon_a;
    int    checks = 0;
    int    errors = 0;
    int    mon_n  = 0;

    // Game-rule model: mode 0 play, 1 caught, 2 over.
    int m_mode, m_lives, m_streak, m_frz, m_inv;
    int gxv, gyv, pxv, pyv;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic step(input bit r, input bit t, input bit s);
        bit    ov, c, rs;
        snap_t e;
        @(negedge clkdiv);
        rst         = r;
        gif.tick    = t;
        gif.start   = s;
        gif.ghost_x = gxv[9:0];
        gif.ghost_y = gyv[8:0];
        gif.pac_x   = pxv[9:0];
        gif.pac_y   = pyv[8:0];
        c  = 1'b0;
        rs = 1'b0;
        if (!r) begin
            m_mode = 0; m_lives = LIVES; m_streak = 0; m_frz = 0; m_inv = 0;
        end else begin
            ov = (iabs(gxv - pxv) < HIT_RADIUS) && (iabs(gyv - pyv) < HIT_RADIUS);
`ifdef GHOST_CATCH_INVULN_EN
            if (m_inv > 0) ov = 1'b0;
`endif
            if (m_mode == 0) begin
                if (t && ov) begin
                    m_streak++;
                    if (m_streak == CONFIRM) begin
                        c = 1'b1;
                        m_streak = 0;
                        m_lives--;
                        if (m_lives == 0) m_mode = 2;
                        else begin m_mode = 1; m_frz = FREEZE_TICKS; end
                    end
                end else if (t) begin
                    m_streak = 0;
                end
            end else if (m_mode == 1) begin
                if (t) begin
                    m_frz--;
                    if (m_frz == 0) begin rs = 1'b1; m_mode = 0; m_streak = 0; end
                end
            end else begin
                if (s) begin m_lives = LIVES; rs = 1'b1; m_mode = 0; m_streak = 0; end
            end
`ifdef GHOST_CATCH_INVULN_EN
            if (rs) m_inv = 31;
            else if (t && m_inv > 0) m_inv--;
`endif
        end
        e.caught    = c;
        e.respawn   = rs;
        e.state     = 2'(m_mode);
        e.lives     = 2'(m_lives);
        e.freeze    = (m_mode != 0);
        e.game_over = (m_mode == 2);
        e.invuln    = (m_inv > 0);
        exp_q.push_back(e);
    endtask

    // One-cycle tick followed by an idle cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic set_pos(input int gx, input int gy, input int px, input int py);
        gxv = gx; gyv = gy; pxv = px; pyv = py;
    endtask

    // Monitor: pop one expectation per presented cycle and compare pulses and status.
    initial begin
        forever begin
            @(posedge clkdiv);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {gif.caught, gif.respawn, gif.state, gif.lives,
                         gif.freeze, gif.game_over, gif.invuln};
                mon_n++;
                checks++;
                if (mon_a[8:7] !== mon_e[8:7]) begin
                    errors++;
                    $display("FAIL pulses n=%0d caught/respawn act=%b exp=%b", mon_n, mon_a[8:7], mon_e[8:7]);
                end
                checks++;
                if (mon_a[6:0] !== mon_e[6:0]) begin
                    errors++;
                    $display("FAIL status n=%0d state,lives,freeze,over,invuln act=%b exp=%b",
                             mon_n, mon_a[6:0], mon_e[6:0]);
                end
            end
        end
    end

    initial begin
        gif.tick = 1'b0; gif.start = 1'b0;
        set_pos(400, 300, 100, 50);

        // Reset state.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);

        // Catch, then the full freeze with Pac-Man away.
        set_pos(200, 146, 205, 150);
        ticks(2);
        set_pos(400, 300, 100, 50);
        ticks(FREEZE_TICKS);
        ticks(35);

        // Glitch rejection.
        set_pos(200, 146, 205, 150); ticks(1);
        set_pos(200, 146, 220, 146); ticks(1);
        set_pos(200, 146, 205, 150); ticks(1);
        set_pos(400, 300, 100, 50);  ticks(1);

        // Radius boundary and no-wrap extremes.
        set_pos(100, 100, 107, 100); ticks(1);
        set_pos(100, 100, 108, 100); ticks(1);
        set_pos(0, 100, 1023, 100);  ticks(2);
        set_pos(1023, 0, 0, 511);    ticks(2);
        set_pos(100, 100, 100, 107); ticks(2);
        set_pos(400, 300, 100, 50);  ticks(40);

        // Run to game over, with start ignored during play and freeze.
        for (int k = 0; k < 200 && m_mode != 2; k++) begin
            set_pos(300, 200, 303, 197);
            step(1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        set_pos(400, 300, 100, 50);
        ticks(3);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);

        // Overlap right after a respawn, then reset mid-freeze.
        ticks(35);
        set_pos(250, 250, 252, 251);
        ticks(2);
        ticks(FREEZE_TICKS);
        ticks(10);
        set_pos(400, 300, 100, 50);
        ticks(40);
        set_pos(250, 250, 252, 251);
        ticks(2);
        set_pos(400, 300, 100, 50);
        ticks(30);
        step(1'b0, 1'b1, 1'b1);
        ticks(3);

        // Randomised play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 15) == 0) begin
                    set_pos(0, 5, 1023, 5);
                end else begin
                    gxv = $urandom_range(10, 1000);
                    gyv = $urandom_range(10, 500);
                    pxv = gxv + int'($urandom_range(0, 20)) - 10;
                    pyv = gyv + int'($urandom_range(0, 20)) - 10;
                end
            end
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 5) == 0));
        end
        step(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clkdiv);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ghost_catch_fsm.md
GHOST_CATCH_FSM -- requirements
Module: ghost_catch_fsm

Interface
REQ-001 The block SHALL have parameter HIT_RADIUS, default 8, meaning per-axis pixel distance below which ghost and Pac-Man overlap.
REQ-002 The block SHALL have parameter LIVES, default 3, meaning starting life count (legal 1..3).
REQ-003 The block SHALL have parameter CONFIRM, default 2, meaning consecutive overlapping ticks required to declare a catch (legal 1..7).
REQ-004 The block SHALL have parameter FREEZE_TICKS, default 60, meaning ticks held in CAUGHT before respawn (legal 1..255).
REQ-005 clkdiv  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 tick  input  1  game-step enable, one clkdiv cycle wide, once per movement step.
REQ-008 ghost_x  input  10  ghost X position, from the ghost movement block.
REQ-009 ghost_y  input  9  ghost Y position.
REQ-010 pac_x  input  10  Pac-Man X position.
REQ-011 pac_y  input  9  Pac-Man Y position.
REQ-012 start  input  1  level-sensitive restart request, honoured only in OVER.
REQ-013 caught  output  1  one-cycle pulse on confirmed catch.
REQ-014 respawn  output  1  one-cycle pulse telling movement blocks to reload start positions.
REQ-015 freeze  output  1  high while movement must hold (CAUGHT or OVER).
REQ-016 lives  output  2  remaining lives.
REQ-017 game_over  output  1  high in OVER.
REQ-018 state  output  2  current state encoding.
REQ-019 invuln  output  1  high during post-respawn invulnerability (see Configuration).

Function
REQ-020 States SHALL be PLAY=2'd0, CAUGHT=2'd1, OVER=2'd2; 2'd3 unreachable and SHALL go to PLAY next cycle.
REQ-021 overlap SHALL be combinational: |ghost_x-pac_x| < HIT_RADIUS AND |ghost_y-pac_y| < HIT_RADIUS, differences computed 11-bit unsigned with absolute value, no wrap.
REQ-022 Overlap SHALL be sampled only on cycles with tick=1; non-tick cycles leave all counters unchanged.
REQ-023 PLAY: on tick with overlap, confirm counter increments; on tick without overlap, it clears to 0.
REQ-024 PLAY: on the tick where confirm counter would reach CONFIRM, the next cycle SHALL assert caught for exactly one cycle, decrement lives, clear confirm counter.
REQ-025 If the decremented lives is 0, next state SHALL be OVER; otherwise CAUGHT with freeze counter loaded to FREEZE_TICKS.
REQ-026 CAUGHT: freeze=1; freeze counter decrements per tick; on the tick where it equals 1, respawn SHALL pulse one cycle and state SHALL return to PLAY with confirm counter 0.
REQ-027 CAUGHT: overlap and start SHALL be ignored.
REQ-028 OVER: freeze=1, game_over=1; start=1 SHALL reload lives=LIVES, pulse respawn one cycle, enter PLAY (tick not required).
REQ-029 start SHALL be ignored in PLAY and CAUGHT.
REQ-030 lives SHALL never underflow; decrement only occurs from PLAY with lives>=1.
REQ-031 caught and respawn SHALL never assert in the same cycle.

Reset
REQ-032 rst=0 at a clkdiv edge SHALL force state=PLAY, lives=LIVES, confirm and freeze counters 0, caught=0, respawn=0, freeze=0, game_over=0, invuln=0, regardless of current state, including mid-freeze.
REQ-033 Reset SHALL take priority over tick and start in the same cycle.

Configuration
REQ-034 Macro GHOST_CATCH_INVULN_EN SHALL gate a post-respawn invulnerability window.
REQ-035 With GHOST_CATCH_INVULN_EN defined: every respawn pulse loads a 5-bit counter with 31; invuln=1 while nonzero; counter decrements per tick; overlap treated as 0 while invuln=1.
REQ-036 Without GHOST_CATCH_INVULN_EN: no counter is built; invuln SHALL be tied 0; overlap always used directly.

Verification
REQ-037 Reset: rst=0 one cycle -> state=0, lives=3, all pulses 0, freeze=0.
REQ-038 Catch: ghost (200,146), pac (205,150), 2 ticks -> caught pulse one cycle after 2nd tick, lives=2, state=1, freeze=1.
REQ-039 Glitch rejection: overlap on tick 1, pac moved to (220,146) on tick 2, overlap on tick 3 -> no caught.
REQ-040 Freeze: after catch, 60 ticks -> respawn pulse on 60th, state=0; tick 59 still state=1.
REQ-041 Game over: 3 catches -> lives=0, state=2, game_over=1; start=1 -> lives=3, respawn pulse, state=0.
REQ-042 Reset mid-freeze at tick 30 of CAUGHT -> state=0, lives=3, freeze=0, no respawn pulse; with GHOST_CATCH_INVULN_EN, overlap within 31 ticks after respawn -> no caught.
